// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
// Package : time_pkg
// BCD time types, limits and helpers shared by the light/chime controller.
// Revision: 1.0
// ============================================================================
package time_pkg;

    typedef logic [7:0]  bcd8_t;
    typedef logic [15:0] bcd_hhmm_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEEP = 2'd1,
        ST_GAP  = 2'd2
    } chime_state_t;

    localparam bcd8_t HOUR_MAX_BCD = 8'h23;
    localparam bcd8_t MIN_MAX_BCD  = 8'h59;
    localparam int    NOON_HOURS   = 12;

    function automatic logic [7:0] bcd2bin8(input bcd8_t v);
        return ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
    endfunction

    // Once every nibble is a decimal digit, a plain byte compare against the
    // BCD maximum enforces the tens/units limits of both hour and minute.
    function automatic logic bcd_hhmm_valid(input bcd_hhmm_t v);
        logic digits_ok;
        digits_ok = (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
                    (v[7:4]   <= 4'd9) && (v[3:0]  <= 4'd9);
        return digits_ok && (v[15:8] <= HOUR_MAX_BCD) && (v[7:0] <= MIN_MAX_BCD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : time_window_ctrl_if
// Time inputs, config write bus and light/chime outputs of time_window_ctrl.
// Revision: 1.0
// ============================================================================
interface time_window_ctrl_if #(
    parameter int NUM_CH = 4
);
    import time_pkg::*;

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    bcd8_t             cur_hour;
    bcd8_t             cur_min;
    bcd8_t             cur_sec;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    bcd_hhmm_t         cfg_on;
    bcd_hhmm_t         cfg_off;
    logic              cfg_en;
    logic              cfg_err;
    logic [NUM_CH-1:0] ch_light;
    logic              chime;
    logic              chime_busy;

    modport master (
        output cur_hour, cur_min, cur_sec,
        output cfg_we, cfg_ch, cfg_on, cfg_off, cfg_en,
        input  cfg_err, ch_light, chime, chime_busy
    );

    modport slave (
        input  cur_hour, cur_min, cur_sec,
        input  cfg_we, cfg_ch, cfg_on, cfg_off, cfg_en,
        output cfg_err, ch_light, chime, chime_busy
    );

endinterface
`default_nettype wire

// File: rtl/chime_seq.sv
`default_nettype none
// ============================================================================
// Module : chime_seq
// Detects the top-of-hour roll and beeps the 12-hour count on the chime strobe.
// Revision: 1.0
// ============================================================================
module chime_seq
    import time_pkg::*;
#(
    parameter int BEEP_ON_CYC  = 500,
    parameter int BEEP_GAP_CYC = 500
) (
    input  logic  clk,
    input  logic  rst,
    input  bcd8_t cur_hour,
    input  bcd8_t cur_min,
    input  bcd8_t cur_sec,
    output logic  chime,
    output logic  chime_busy
);

    localparam int CYC_MAX = (BEEP_ON_CYC > BEEP_GAP_CYC) ? BEEP_ON_CYC : BEEP_GAP_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BEEP_ON_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BEEP_GAP_CYC - 1);

    chime_state_t     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_remain, w_remain_nxt;
    bcd8_t            r_prev_sec;
    logic             w_trigger;
    logic [7:0]       w_hour_bin;
    logic [3:0]       w_beeps;

    // Requiring a non-zero previous second makes a held 00:00 fire only once.
    assign w_trigger = (cur_min == 8'h00) && (cur_sec == 8'h00) && (r_prev_sec != 8'h00);

    always_comb begin
        w_hour_bin = bcd2bin8(cur_hour);
        if (w_hour_bin == 8'd0 || w_hour_bin == 8'(NOON_HOURS))
            w_beeps = 4'(NOON_HOURS);
        else if (w_hour_bin < 8'(NOON_HOURS))
            w_beeps = w_hour_bin[3:0];
        else
            w_beeps = 4'(w_hour_bin - 8'(NOON_HOURS));
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_remain_nxt = r_remain;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger && w_beeps != 4'd0) begin
                    w_state_nxt  = ST_BEEP;
                    w_cnt_nxt    = '0;
                    w_remain_nxt = w_beeps;
                end
            end
            ST_BEEP: begin
                if (r_cnt == ON_LAST) begin
                    w_cnt_nxt    = '0;
                    w_remain_nxt = r_remain - 4'd1;
                    w_state_nxt  = (r_remain > 4'd1) ? ST_GAP : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BEEP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_remain   <= 4'd0;
            r_prev_sec <= 8'h00;
            chime      <= 1'b0;
            chime_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_remain   <= w_remain_nxt;
            r_prev_sec <= cur_sec;
            chime      <= (w_state_nxt == ST_BEEP);
            chime_busy <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: rtl/time_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module : time_window_ctrl
// Programmable per-channel BCD on/off light windows plus the hourly chime.
// Revision: 1.0
// ============================================================================
module time_window_ctrl
    import time_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int BEEP_ON_CYC  = 500,
    parameter int BEEP_GAP_CYC = 500
) (
    input  logic              clk,
    input  logic              rst,
    time_window_ctrl_if.slave bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    bcd_hhmm_t         r_on  [NUM_CH];
    bcd_hhmm_t         r_off [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    bcd_hhmm_t         w_t;
    logic              w_wr_ok;
    logic [NUM_CH-1:0] w_hit;

    assign w_t     = {bus.cur_hour, bus.cur_min};
    assign w_wr_ok = bcd_hhmm_valid(bus.cfg_on) && bcd_hhmm_valid(bus.cfg_off) &&
                     ({1'b0, bus.cfg_ch} < (CH_W+1)'(NUM_CH));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_on[i]  <= '0;
                r_off[i] <= '0;
            end
            r_en         <= '0;
            bus.cfg_err  <= 1'b0;
            bus.ch_light <= '0;
        end else begin
            bus.cfg_err  <= bus.cfg_we && !w_wr_ok;
            bus.ch_light <= w_hit;
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.cfg_we && w_wr_ok && bus.cfg_ch == CH_W'(i)) begin
                    r_on[i]  <= bus.cfg_on;
                    r_off[i] <= bus.cfg_off;
                    r_en[i]  <= bus.cfg_en;
                end
            end
        end
    end

    // BCD digits order like binary, so windows compare as plain 16-bit values.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_hit[gi] = r_en[gi] && (
                (r_on[gi] < r_off[gi]) ? ((w_t >= r_on[gi]) && (w_t < r_off[gi])) :
                (r_on[gi] > r_off[gi]) ? ((w_t >= r_on[gi]) || (w_t < r_off[gi])) :
                1'b0);
        end
    endgenerate

    chime_seq #(
        .BEEP_ON_CYC  (BEEP_ON_CYC),
        .BEEP_GAP_CYC (BEEP_GAP_CYC)
    ) u_chime_seq (
        .clk        (clk),
        .rst        (rst),
        .cur_hour   (bus.cur_hour),
        .cur_min    (bus.cur_min),
        .cur_sec    (bus.cur_sec),
        .chime      (bus.chime),
        .chime_busy (bus.chime_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_time_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_time_window_ctrl
// Directed checks of light windows, config rejection, chime counts and reset.
// Revision: 1.0
// ============================================================================
module tb_time_window_ctrl;

    localparam int NUM_CH = 3;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses, highs, busy_cyc, pat_err;

    time_window_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    time_window_ctrl #(
        .NUM_CH       (NUM_CH),
        .BEEP_ON_CYC  (2),
        .BEEP_GAP_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus.cur_hour = h;
        bus.cur_min  = m;
        bus.cur_sec  = s;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] on, input logic [15:0] off,
                             input logic en);
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = ch;
        bus.cfg_on  = on;
        bus.cfg_off = off;
        bus.cfg_en  = en;
        step();
        bus.cfg_we  = 1'b0;
    endtask

    // Steps from the trigger edge, counting pulses and comparing against the
    // hand-derived 2-on/2-off pattern for n beeps.
    task automatic run_chime(input int cycles, input int n, input int glitch_at,
                             output int o_pulses, output int o_highs, output int o_busy,
                             output int o_pat_err);
        logic prev_c;
        logic exp_busy, exp_chime;
        prev_c = 1'b0;
        o_pulses = 0; o_highs = 0; o_busy = 0; o_pat_err = 0;
        for (int i = 0; i < cycles; i++) begin
            if (i == glitch_at)     bus.cur_sec = 8'h01;
            if (i == glitch_at + 1) bus.cur_sec = 8'h00;
            step();
            if (bus.chime && !prev_c) o_pulses++;
            if (bus.chime)            o_highs++;
            if (bus.chime_busy)       o_busy++;
            exp_busy  = (i < 4 * n - 2);
            exp_chime = exp_busy && ((i % 4) < 2);
            if (bus.chime !== exp_chime || bus.chime_busy !== exp_busy) o_pat_err++;
            prev_c = bus.chime;
        end
    endtask

    logic [15:0] tv_time [6];
    logic [2:0]  tv_exp  [6];

    initial begin
        rst = 1'b1;
        set_time(8'h00, 8'h00, 8'h00);
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_on = '0; bus.cfg_off = '0; bus.cfg_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_ch_light", 32'(bus.ch_light), 0);
        check("rst_chime", 32'(bus.chime), 0);
        check("rst_busy", 32'(bus.chime_busy), 0);
        check("rst_cfg_err", 32'(bus.cfg_err), 0);

        // Normal window 07:00-19:30 on ch0
        cfg_write(2'd0, 16'h0700, 16'h1930, 1'b1);
        check("wr_ok_err", 32'(bus.cfg_err), 0);
        set_time(8'h06, 8'h59, 8'h00); step();
        check("ch0_0659", 32'(bus.ch_light[0]), 0);
        set_time(8'h07, 8'h00, 8'h00); #1;
        check("ch0_0700_pre_edge", 32'(bus.ch_light[0]), 0);
        step();
        check("ch0_0700", 32'(bus.ch_light[0]), 1);
        set_time(8'h19, 8'h29, 8'h00); step();
        check("ch0_1929", 32'(bus.ch_light[0]), 1);
        set_time(8'h19, 8'h30, 8'h00); step();
        check("ch0_1930", 32'(bus.ch_light[0]), 0);

        // Midnight wrap on ch1, degenerate on==off on ch2
        cfg_write(2'd1, 16'h2200, 16'h0600, 1'b1);
        cfg_write(2'd2, 16'h1200, 16'h1200, 1'b1);
        tv_time[0] = 16'h2159; tv_exp[0] = 3'b000;
        tv_time[1] = 16'h2200; tv_exp[1] = 3'b010;
        tv_time[2] = 16'h0000; tv_exp[2] = 3'b010;
        tv_time[3] = 16'h0559; tv_exp[3] = 3'b010;
        tv_time[4] = 16'h0600; tv_exp[4] = 3'b000;
        tv_time[5] = 16'h1200; tv_exp[5] = 3'b001;
        for (int k = 0; k < 6; k++) begin
            set_time(tv_time[k][15:8], tv_time[k][7:0], 8'h00);
            step();
            check($sformatf("wrap_%04h", tv_time[k]), 32'(bus.ch_light), 32'(tv_exp[k]));
        end

        // Rejected writes leave ch1 untouched
        set_time(8'h23, 8'h00, 8'h00); step();
        check("ch1_2300_before", 32'(bus.ch_light), 32'b010);
        cfg_write(2'd1, 16'h2400, 16'h0600, 1'b0);
        check("err_hour24", 32'(bus.cfg_err), 1);
        step();
        check("err_one_cycle", 32'(bus.cfg_err), 0);
        cfg_write(2'd1, 16'h1200, 16'h1260, 1'b0);
        check("err_min60", 32'(bus.cfg_err), 1);
        cfg_write(2'd1, 16'h1A00, 16'h0600, 1'b0);
        check("err_nibble", 32'(bus.cfg_err), 1);
        cfg_write(2'd3, 16'h0700, 16'h1900, 1'b1);
        check("err_channel", 32'(bus.cfg_err), 1);
        step();
        check("err_clear", 32'(bus.cfg_err), 0);
        check("invalid_no_change", 32'(bus.ch_light), 32'b010);

        // Valid disable shows two edges after the strobe
        cfg_write(2'd1, 16'h2200, 16'h0600, 1'b0);
        check("dis_err", 32'(bus.cfg_err), 0);
        check("dis_edge1", 32'(bus.ch_light), 32'b010);
        step();
        check("dis_edge2", 32'(bus.ch_light), 32'b000);

        // Chime: 15:00 -> 3 beeps
        check("chime_idle", 32'(bus.chime_busy), 0);
        set_time(8'h14, 8'h59, 8'h59); step();
        set_time(8'h15, 8'h00, 8'h00);
        run_chime(60, 3, -1, pulses, highs, busy_cyc, pat_err);
        check("c15_pulses", 32'(pulses), 3);
        check("c15_highs", 32'(highs), 6);
        check("c15_busy", 32'(busy_cyc), 10);
        check("c15_pattern", 32'(pat_err), 0);

        // 00:00 -> 12 beeps
        set_time(8'h23, 8'h59, 8'h59); step();
        set_time(8'h00, 8'h00, 8'h00);
        run_chime(60, 12, -1, pulses, highs, busy_cyc, pat_err);
        check("c00_pulses", 32'(pulses), 12);
        check("c00_busy", 32'(busy_cyc), 46);
        check("c00_pattern", 32'(pat_err), 0);

        // 13:00 -> 1 beep
        set_time(8'h12, 8'h59, 8'h59); step();
        set_time(8'h13, 8'h00, 8'h00);
        run_chime(30, 1, -1, pulses, highs, busy_cyc, pat_err);
        check("c13_pulses", 32'(pulses), 1);
        check("c13_busy", 32'(busy_cyc), 2);
        check("c13_pattern", 32'(pat_err), 0);

        // Retrigger while busy is ignored
        set_time(8'h14, 8'h59, 8'h59); step();
        set_time(8'h15, 8'h00, 8'h00);
        run_chime(60, 3, 3, pulses, highs, busy_cyc, pat_err);
        check("retrig_pulses", 32'(pulses), 3);
        check("retrig_busy", 32'(busy_cyc), 10);
        check("retrig_pattern", 32'(pat_err), 0);

        // Reset during the second beep of a 12:00 sequence
        set_time(8'h11, 8'h59, 8'h59); step();
        set_time(8'h12, 8'h00, 8'h00); step();
        check("rm_first_beep", 32'(bus.chime), 1);
        step(); step(); step(); step();
        check("rm_second_beep", 32'(bus.chime), 1);
        check("rm_light_before", 32'(bus.ch_light), 32'b001);
        rst = 1'b1; step();
        check("rm_chime", 32'(bus.chime), 0);
        check("rm_busy", 32'(bus.chime_busy), 0);
        check("rm_light", 32'(bus.ch_light), 0);
        rst = 1'b0; step(); step();
        check("rm_cfg_cleared", 32'(bus.ch_light), 0);
        check("rm_no_retrigger", 32'(bus.chime_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_window_ctrl.md
Name: time_window_ctrl

Overview:
- Replaces the fixed "hour ≥ 12" light flag with NUM_CH programmable BCD on/off windows and an hourly chime sequencer.
- Sits beside the clock counter. Consumes the current BCD hour, minute and second, and drives per-channel light enables plus a beep strobe for the buzzer driver.
- All outputs are registered.

Parameters:
- NUM_CH, 4: number of independent light channels (1..8).
- BEEP_ON_CYC, 500: clk cycles the chime is high per beep (≥1).
- BEEP_GAP_CYC, 500: clk cycles low between beeps (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cur_hour  in  8  BCD hour 00..23 ([7:4] tens, [3:0] units).
- cur_min  in  8  BCD minute 00..59.
- cur_sec  in  8  BCD second 00..59.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W=max(1,$clog2(NUM_CH))  target channel.
- cfg_on  in  16  BCD hh:mm window start.
- cfg_off  in  16  BCD hh:mm window end.
- cfg_en  in  1  channel enable written with the window.
- cfg_err  out  1  one-cycle pulse: rejected write.
- ch_light  out  NUM_CH  per-channel light enable.
- chime  out  1  beep strobe.
- chime_busy  out  1  high while a chime sequence runs.

Behaviour:
- Reset values:
  - ch_light=0, chime=0, chime_busy=0, cfg_err=0.
  - All channel registers: on=0000, off=0000, en=0.
  - Chime FSM in IDLE; previous-second register = 00.
- Config write, on cfg_we:
  - Validity rules:
    - every nibble ≤ 9;
    - hour ≤ 23 (tens ≤ 2, and units ≤ 3 when tens = 2);
    - minute tens ≤ 5;
    - cfg_ch < NUM_CH.
  - Valid write: registers updated at that edge; cfg_err=0.
  - Invalid write: nothing is written; cfg_err=1 for exactly the next cycle.
  - Writes always succeed regardless of chime state.
- Window compare:
  - t = {cur_hour, cur_min}. Compare as 16-bit unsigned; BCD preserves ordering.
  - on < off: lit when on ≤ t < off.
  - on > off (crosses midnight): lit when t ≥ on or t < off.
  - on == off: never lit.
  - en=0: never lit.
  - ch_light[i] is registered; it reflects the inputs and config sampled at the previous edge (1-cycle latency).
  - A config write takes effect on ch_light two edges after cfg_we.
- Chime trigger:
  - prev_sec is registered every cycle.
  - Trigger fires when cur_min=00, cur_sec=00 and prev_sec≠00. This gives exactly one trigger per hour roll, even with a slow tick.
  - Beep count N comes from the 12-hour value: hour 0 or 12 → 12; 1..11 → h; 13..23 → h−12. Binary conversion is tens×10+units.
- Chime FSM, states IDLE, BEEP, GAP:
  - IDLE → BEEP on trigger. Load remaining=N and a cycle counter.
  - BEEP: chime=1 for BEEP_ON_CYC cycles, then decrement remaining. Go to GAP if remaining>0, else IDLE.
  - GAP: chime=0 for BEEP_GAP_CYC cycles, then → BEEP.
  - chime_busy=1 in BEEP and GAP.
  - A trigger while busy is ignored; no queueing.
  - Counters are sized $clog2(max(BEEP_ON_CYC, BEEP_GAP_CYC)+1); the remaining counter is 4 bits.
- rst mid-sequence aborts the chime: chime=0 and FSM in IDLE on the next edge.
- Invalid BCD on cur_* is not checked. The compare still runs numerically; no trigger fires unless the value is exactly 00.

Decomposition:
- Package time_pkg:
  - typedef bcd8_t (8-bit BCD pair) and bcd_hhmm_t (16-bit);
  - constants HOUR_MAX_BCD=8'h23, MIN_MAX_BCD=8'h59, NOON_HOURS=12;
  - function bcd2bin8;
  - function bcd_hhmm_valid.
- Sub-module chime_seq: the trigger detect plus the IDLE/BEEP/GAP FSM, parametrised by BEEP_ON_CYC and BEEP_GAP_CYC.
- time_window_ctrl holds the config register file and the NUM_CH compare generate loop.

Test Plan:
- Normal window (BEEP_ON_CYC=BEEP_GAP_CYC=2): write ch0 on=0700, off=1930, en=1; sweep t 06:59, 07:00, 19:29, 19:30 → ch_light[0] = 0, 1, 1, 0, each 1 cycle after the input.
- Midnight wrap: ch1 on=2200, off=0600. Times 21:59, 22:00, 00:00, 05:59, 06:00 → 0, 1, 1, 1, 0. Also ch2 on=off=1200, en=1 → always 0.
- Invalid writes: cfg_on=2400, cfg_off=1260, cfg_on=1A00, and cfg_ch=NUM_CH each → cfg_err=1 for one cycle; a readback-by-effect shows the channel is unchanged. A valid write → cfg_err=0.
- Chime count: step 14:59:59 → 15:00:00 → chime shows 3 high pulses of 2 cycles, separated by 2-cycle gaps; chime_busy=1 for 2×3+2×2=10 cycles. Step 23:59:59 → 00:00:00 → 12 pulses. Step 12:59:59 → 13:00:00 → 1 pulse.
- Retrigger/hold: hold 15:00:00 for 50 cycles → only one sequence. Force a second trigger while busy → ignored, and the pulse count is still 3.
- Reset mid-operation: assert rst during the 2nd beep → the next edge gives chime=0, chime_busy=0, ch_light=0, and all config cleared (ch0 now dark at 12:00).
